// File: rtl/ibex_rf_wb_arbiter.sv
// Register-file write-port arbiter: a 2-entry EX writeback queue and a
// direct LSU path share one write port, with starvation and WAW ordering.
module ibex_rf_wb_arbiter #(
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned StarveLimit = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 ex_valid_i,
  output logic                 ex_ready_o,
  input  logic [4:0]           ex_waddr_i,
  input  logic [DataWidth-1:0] ex_wdata_i,
  input  logic                 lsu_valid_i,
  output logic                 lsu_ready_o,
  input  logic [4:0]           lsu_waddr_i,
  input  logic [DataWidth-1:0] lsu_wdata_i,
  output logic                 we_a_o,
  output logic [4:0]           waddr_a_o,
  output logic [DataWidth-1:0] wdata_a_o,
  input  logic [4:0]           raddr_a_i,
  input  logic [4:0]           raddr_b_i,
  output logic                 busy_a_o,
  output logic                 busy_b_o
);

  localparam logic [2:0] Limit = 3'(StarveLimit);

  logic [1:0]           count_q;
  logic                 wr_ptr_q;
  logic                 rd_ptr_q;
  logic [2:0]           wait_q;
  logic [4:0]           addr_q [2];
  logic [DataWidth-1:0] data_q [2];

  logic                 head_valid;
  logic                 tail_valid;
  logic [4:0]           head_addr;
  logic [4:0]           tail_addr;
  logic [DataWidth-1:0] head_data;
  logic                 lsu_match;
  logic                 starved;
  logic                 fifo_win;
  logic                 lsu_win;
  logic                 push;
  logic                 pop;
  logic [4:0]           sel_addr;
  logic [DataWidth-1:0] sel_data;

  assign head_valid = (count_q != 2'd0);
  assign tail_valid = (count_q == 2'd2);
  assign head_addr  = addr_q[rd_ptr_q];
  assign tail_addr  = addr_q[~rd_ptr_q];
  assign head_data  = data_q[rd_ptr_q];

  // Any queued write to the LSU's target must retire first (WAW order).
  assign lsu_match = lsu_valid_i &&
                     ((head_valid && head_addr == lsu_waddr_i) ||
                      (tail_valid && tail_addr == lsu_waddr_i));

  assign starved  = (wait_q >= Limit);
  assign fifo_win = head_valid &&
                    (!lsu_valid_i || starved || lsu_match);
  assign lsu_win  = lsu_valid_i && !fifo_win;

  assign ex_ready_o  = (count_q != 2'd2);
  assign lsu_ready_o = lsu_win;
  assign push        = ex_valid_i && ex_ready_o;
  assign pop         = fifo_win;

  always_comb begin
    sel_addr = 5'd0;
    sel_data = '0;
    unique case (1'b1)
      fifo_win: begin
        sel_addr = head_addr;
        sel_data = head_data;
      end
      lsu_win: begin
        sel_addr = lsu_waddr_i;
        sel_data = lsu_wdata_i;
      end
      default: ;
    endcase
  end

  // x0 writes are consumed but never reach the register file.
  assign we_a_o    = (fifo_win || lsu_win) && (sel_addr != 5'd0);
  assign waddr_a_o = we_a_o ? sel_addr : 5'd0;
  assign wdata_a_o = we_a_o ? sel_data : '0;

  assign busy_a_o = (raddr_a_i != 5'd0) &&
                    ((head_valid && head_addr == raddr_a_i) ||
                     (tail_valid && tail_addr == raddr_a_i) ||
                     (lsu_valid_i && lsu_waddr_i == raddr_a_i));

  assign busy_b_o = (raddr_b_i != 5'd0) &&
                    ((head_valid && head_addr == raddr_b_i) ||
                     (tail_valid && tail_addr == raddr_b_i) ||
                     (lsu_valid_i && lsu_waddr_i == raddr_b_i));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q[0] <= 5'd0;
      addr_q[1] <= 5'd0;
      data_q[0] <= '0;
      data_q[1] <= '0;
    end else if (push) begin
      addr_q[wr_ptr_q] <= ex_waddr_i;
      data_q[wr_ptr_q] <= ex_wdata_i;
    end
  end

  // A valid head that is not popped has lost to the LSU this cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wait_q <= 3'd0;
    end else if (!head_valid || pop) begin
      wait_q <= 3'd0;
    end else if (wait_q != 3'd7) begin
      wait_q <= wait_q + 3'd1;
    end
  end

endmodule
